// File: rtl/fifo_mem_pkg.sv
// rtl/fifo_mem_pkg.sv - shared widths and word/address types for the FIFO storage array
package fifo_mem_pkg;

  localparam int DATA_WIDTH = 15;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/fifo_memory_unit.sv
// rtl/fifo_memory_unit.sv - simple dual-port register file with registered read data
// FIFO_MEMORY_UNIT_BYPASS_EN: same-address write/read forwards dataIn (default returns old data)
module fifo_memory_unit
  import fifo_mem_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_mem_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] wrAddress,
  input  logic [ADDR_WIDTH-1:0] rdAddress,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Storage is flops rather than a RAM macro so that reset can clear every word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[wrAddress] <= dataIn;
    end
  end

  always_comb begin
    rd_word = mem[rdAddress];
`ifdef FIFO_MEMORY_UNIT_BYPASS_EN
    if (wen && (wrAddress == rdAddress)) begin
      rd_word = dataIn;
    end
`endif
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      dataValid <= ren;
      if (ren) begin
        dataOut <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_fifo_memory_unit.sv
// tb/tb_fifo_memory_unit.sv - scoreboard bench for fifo_memory_unit, directed plan plus random traffic
module tb_fifo_memory_unit;
  import fifo_mem_pkg::*;

  logic  clock = 1'b0;
  logic  resetN;
  data_t dataIn;
  addr_t wrAddress;
  addr_t rdAddress;
  logic  wen;
  logic  ren;
  data_t dataOut;
  logic  dataValid;

  always #5 clock = ~clock;

  fifo_memory_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clock    (clock),
    .resetN   (resetN),
    .dataIn   (dataIn),
    .wrAddress(wrAddress),
    .rdAddress(rdAddress),
    .wen      (wen),
    .ren      (ren),
    .dataOut  (dataOut),
    .dataValid(dataValid)
  );

  typedef struct {
    logic  v;
    data_t d;
  } exp_t;

  exp_t  sb[$];
  data_t model[DEPTH];
  data_t last_out;
  int    checks = 0;
  int    passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Expected result is taken from the model before the write lands, giving read-old-data.
  task automatic op(input bit w, input addr_t wa, input data_t wd, input bit r, input addr_t ra);
    exp_t e;
    wen       = w;
    wrAddress = wa;
    dataIn    = wd;
    ren       = r;
    rdAddress = ra;
    e.v = r;
    if (r) begin
      e.d = model[ra];
`ifdef FIFO_MEMORY_UNIT_BYPASS_EN
      if (w && wa == ra) e.d = wd;
`endif
      last_out = e.d;
    end else begin
      e.d = last_out;
    end
    if (w) model[wa] = wd;
    @(posedge clock);
    sb.push_back(e);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_out = '0;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dataValid", {31'd0, dataValid}, {31'd0, e.v});
      check("dataOut", {17'd0, dataOut}, {17'd0, e.d});
    end else if (resetN && dataValid) begin
      check("unexpected_valid", {31'd0, dataValid}, 32'd0);
    end
  end

  initial begin
    bit    w, r;
    addr_t wa, ra;
    resetN = 1'b0;
    wen = 1'b0; ren = 1'b0;
    dataIn = '0; wrAddress = '0; rdAddress = '0;
    clear_model();
    #12;
    check("reset_dataOut", {17'd0, dataOut}, 32'd0);
    check("reset_dataValid", {31'd0, dataValid}, 32'd0);
    @(posedge clock); #1 resetN = 1'b1;

    // plan 1: idle read of an unwritten word
    op(0, 0, 0, 1, 3);
    // plan 2 and 3: writes, reads, then hold
    op(1, 0, 10, 0, 0);
    op(1, 1, 11, 0, 0);
    op(1, 2, 12, 0, 0);
    for (int i = 0; i < 6; i++) op(0, 0, 0, 1, addr_t'(i));
    op(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) op(0, 0, 0, 0, 0);
    // plan 4: same-address collision
    op(1, 5, 7, 0, 0);
    op(1, 5, 99, 1, 5);
    op(0, 0, 0, 1, 5);
    // plan 5: different-address simultaneous access at the top address
    op(1, 15, 20, 1, 0);
    op(0, 0, 0, 1, 15);
    // plan 6: asynchronous reset mid-operation
    op(1, 4, 33, 0, 0);
    op(0, 0, 0, 1, 4);
    @(negedge clock); #2;
    ren = 1'b1; rdAddress = 4;
    #1 sb.delete();
    resetN = 1'b0;
    clear_model();
    #1;
    check("async_reset_dataOut", {17'd0, dataOut}, 32'd0);
    check("async_reset_dataValid", {31'd0, dataValid}, 32'd0);
    @(posedge clock); @(posedge clock); #1 resetN = 1'b1;
    op(0, 0, 0, 1, 4);

    // random traffic, biased towards same-address collisions
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 3) != 0);
      wa = addr_t'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, DEPTH - 1));
      op(w, wa, data_t'($urandom), r, ra);
    end
    op(0, 0, 0, 0, 0);
    @(negedge clock); #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
